// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction at a time on a valid/ack bus,
// with byte-lane steering, alignment/funct3 checks, load extension and a timeout.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic            req_legal;
    logic            req_misal;
    logic            req_bad;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] sh16;
        sh   = word >> {off, 3'b000};
        sb   = sh[7:0];
        sh16 = sh[15:0];
        case (f3)
            3'b000:  return 32'(sb);
            3'b001:  return 32'(sh16);
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    always_comb begin
        req_legal = 1'b0;
        req_misal = 1'b0;
        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                     || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_bad   = !req_legal || req_misal;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid) state_nx = req_bad ? DONE : BUSY;
            BUSY: if (mem_ack || (cnt == CNT_LAST)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign stall     = ~rst & (((state == IDLE) & req_valid) | (state == BUSY));
    assign mem_req   = (state == BUSY);
    assign rsp_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt <= '0;
                        if (req_bad) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= lane_be(req_funct3[1:0], req_addr[1:0]);
                            mem_wdata <= req_we ? lane_wdata(req_funct3[1:0], req_wdata) : 32'd0;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the last allowed cycle takes priority over the timeout.
                    if (mem_ack) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= mem_we ? 32'd0 : load_extract(funct3_q, off_q, mem_rdata);
                    end else if (cnt == CNT_LAST) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    if (state_nx == DONE) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                    end
                end
                DONE: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    // Access attributes needed at completion time; data only, no reset needed.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_valid) begin
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
        end
    end

endmodule
